uart_tx_fifo: RTL and testbench

- UART transmitter that drives the board's UART_TX line; the counterpart of the CPU's UART receive path.
- The CPU-side peripheral logic pushes bytes into a small FIFO through a valid/ready handshake.
- The block serialises each byte as an 8N1 frame (LSB first) at a fixed baud rate derived from sysclk.
- It sits between the pipeline's memory-mapped UART peripheral and the UART_TX pin.

---
 rtl/uart_tx_fifo.sv | 146 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : 8N1 UART transmitter fed by a small valid/ready byte FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int BAUD_DIV   = CLK_FREQ / BAUD,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          sysclk,
    input  logic                          reset,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          UART_TX,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_CW = $clog2(BAUD_DIV);

    localparam logic [c_AW:0]   c_FULL      = (c_AW + 1)'(FIFO_DEPTH);
    localparam logic [c_CW-1:0] c_BAUD_LAST = c_CW'(BAUD_DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_AW-1:0] r_wptr;
    logic [c_AW-1:0] r_rptr;
    logic [c_AW:0]   r_count;

    logic [1:0]      r_state;
    logic [c_CW-1:0] r_baud_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic            r_tx;

    logic w_push;
    logic w_pop;
    logic w_bit_end;

    // Ready comes from the registered count only, so a full FIFO never
    // accepts a byte even on a cycle where the head is being popped.
    assign tx_ready   = (r_count != c_FULL);
    assign w_push     = tx_valid & tx_ready;
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
    assign w_bit_end  = (r_baud_cnt == c_BAUD_LAST);

    assign UART_TX    = r_tx;
    assign fifo_count = r_count;
    assign tx_busy    = (r_state != S_IDLE) || (r_count != '0);

    always_ff @(posedge sysclk) begin
        if (w_push) begin
            r_mem[r_wptr] <= tx_data;
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The line is driven from the state held before each edge, so it lags
    // the FSM by one cycle and each symbol lasts exactly BAUD_DIV cycles.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift    <= r_mem[r_rptr];
                        r_baud_cnt <= '0;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    r_tx <= 1'b0;
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_state    <= S_DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    r_tx <= r_shift[r_bit_idx];
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_state    <= S_IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_fifo
// Description : Self-checking bench for uart_tx_fifo with a frame decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int BD = 16;

    logic       sysclk   = 1'b0;
    logic       reset    = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       UART_TX;
    logic       tx_busy;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Bytes offered by the producer, in the order they must appear on the line.
    logic [7:0] expq[$];

    uart_tx_fifo #(
        .CLK_FREQ   (16),
        .BAUD       (1),
        .BAUD_DIV   (BD),
        .FIFO_DEPTH (4)
    ) dut (
        .sysclk     (sysclk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .UART_TX    (UART_TX),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #5 sysclk = ~sysclk;
    always @(posedge sysclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [7:0] d, output int acc);
        acc = -1;
        expq.push_back(d);
        tx_data  = d;
        tx_valid = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            if (tx_ready === 1'b1) begin
                acc = cyc + 1;
                @(negedge sysclk);
                break;
            end
            @(negedge sysclk);
        end
        tx_valid = 1'b0;
        chk("push_accepted", acc >= 0, 1'b1);
    endtask

    // Waits for a start bit, samples each symbol mid-bit, checks against the queue.
    task automatic decode(output int start_cyc);
        logic [7:0] got;
        logic [7:0] exp;
        got = 8'h00;
        start_cyc = -1;
        for (int n = 0; n < 3000; n++) begin
            if (UART_TX === 1'b0) begin
                start_cyc = cyc;
                break;
            end
            @(negedge sysclk);
        end
        chk("frame_start_seen", start_cyc >= 0, 1'b1);
        if (start_cyc >= 0) begin
            repeat (BD / 2) @(negedge sysclk);
            chk("start_bit", UART_TX, 1'b0);
            for (int k = 0; k < 8; k++) begin
                repeat (BD) @(negedge sysclk);
                got[k] = UART_TX;
            end
            repeat (BD) @(negedge sysclk);
            chk("stop_bit", UART_TX, 1'b1);
            exp = (expq.size() > 0) ? expq.pop_front() : 8'hxx;
            chk("frame_data", got, exp);
        end
    endtask

    initial begin
        int acc, a0, a5, s1, s2, lows;
        logic [7:0] r;

        // Asynchronous reset before any clock edge
        #2 reset = 1'b1;
        #1;
        chk("rst_line", UART_TX, 1'b1);
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_busy", tx_busy, 1'b0);
        chk("rst_count", fifo_count, 3'd0);
        @(negedge sysclk);
        @(negedge sysclk);
        reset = 1'b0;

        // Single byte: latency and frame length
        push(8'h18, acc);
        chk("lat_count_push", fifo_count, 3'd1);
        chk("lat_line_n", UART_TX, 1'b1);
        chk("lat_busy", tx_busy, 1'b1);
        @(negedge sysclk);
        chk("lat_count_pop", fifo_count, 3'd0);
        chk("lat_line_n1", UART_TX, 1'b1);
        @(negedge sysclk);
        chk("lat_line_n2", UART_TX, 1'b0);
        decode(s1);
        chk("lat_start_edge", s1 - acc, 2);
        repeat (BD / 2 - 2) @(negedge sysclk);
        chk("busy_last_stop_cycle", tx_busy, 1'b1);
        @(negedge sysclk);
        chk("busy_after_frame", tx_busy, 1'b0);
        chk("line_after_frame", UART_TX, 1'b1);

        // Back-to-back frames; second push coincides with the pop
        repeat (4) @(negedge sysclk);
        push(8'h18, a0);
        push(8'h78, acc);
        chk("b2b_consecutive", acc - a0, 1);
        chk("pushpop_count", fifo_count, 3'd1);
        decode(s1);
        decode(s2);
        chk("b2b_spacing", s2 - s1, 10 * BD + 1);
        repeat (BD) @(negedge sysclk);

        // FIFO full: A5 held until A1 leaves the FIFO
        fork
            begin
                push(8'hA0, a0);
                push(8'hA1, acc);
                push(8'hA2, acc);
                push(8'hA3, acc);
                push(8'hA4, acc);
                chk("full_count", fifo_count, 3'd4);
                chk("full_ready", tx_ready, 1'b0);
                push(8'hA5, a5);
                chk("a5_accept_edge", a5 - a0, 10 * BD + 3);
            end
            begin
                for (int i = 0; i < 6; i++) decode(s1);
            end
        join
        chk("full_drained", expq.size(), 0);
        repeat (BD) @(negedge sysclk);

        // Random bytes with random gaps
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge sysclk);
                    r = 8'($urandom);
                    push(r, acc);
                end
            end
            begin
                for (int i = 0; i < 8; i++) decode(s1);
            end
        join
        chk("rand_drained", expq.size(), 0);
        repeat (BD) @(negedge sysclk);

        // Reset during data bit 3 with three bytes queued
        push(8'hF0, a0);
        push(8'h11, acc);
        push(8'h22, acc);
        push(8'h33, acc);
        repeat (71) @(negedge sysclk);
        chk("pre_reset_line", UART_TX, 1'b0);
        chk("pre_reset_count", fifo_count, 3'd3);
        #2 reset = 1'b1;
        #1;
        chk("midrst_line", UART_TX, 1'b1);
        chk("midrst_count", fifo_count, 3'd0);
        chk("midrst_busy", tx_busy, 1'b0);
        chk("midrst_ready", tx_ready, 1'b1);
        @(negedge sysclk);
        reset = 1'b0;
        expq.delete();
        lows = 0;
        repeat (12 * BD) begin
            @(negedge sysclk);
            if (UART_TX !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        chk("quiet_after_reset", lows, 0);
        push(8'h5A, acc);
        decode(s1);
        chk("recover_drained", expq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
